// File: rtl/sfence_vma_seq_pkg.sv
// rtl/sfence_vma_seq_pkg.sv - shared decode, privilege and SFENCE.VMA types for the execute stage
package sfence_vma_seq_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_e;

  typedef enum logic [1:0] {
    SFENCE_ALL       = 2'd0,
    SFENCE_ADDR      = 2'd1,
    SFENCE_ASID      = 2'd2,
    SFENCE_ADDR_ASID = 2'd3
  } sfence_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } sfence_state_e;

  localparam logic [6:0] FUNCT7_SFENCE_VMA = 7'h09;
  localparam logic [2:0] FUNCT3_PRIV       = 3'b000;

  // Bit 0 flags a VA operand, bit 1 an ASID operand; the enum encoding follows.
  function automatic sfence_kind_e sfence_kind(input logic rs1_nz, input logic rs2_nz);
    return sfence_kind_e'({rs2_nz, rs1_nz});
  endfunction

endpackage

// File: rtl/sfence_vma_seq_ack_tracker.sv
// rtl/sfence_vma_seq_ack_tracker.sv - generic pending mask for req/ack broadcasts
// load sets every bit, flush clears every bit, an ack clears only its own pending bit.
module sfence_ack_tracker #(
  parameter int NUM_CH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic [NUM_CH-1:0] ack,
  output logic [NUM_CH-1:0] pending,
  output logic              all_clear
);

  logic [NUM_CH-1:0] pending_d;
  logic [NUM_CH-1:0] pending_q;

  always_comb begin
    pending_d = pending_q & ~ack;
    if (flush) pending_d = '0;
    if (load)  pending_d = '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign pending   = pending_q;
  assign all_clear = ~|pending_q;

endmodule

// File: rtl/sfence_vma_seq.sv
// rtl/sfence_vma_seq.sv - SFENCE.VMA decode, privilege check and TLB invalidate broadcast
// Optional ack watchdog: define SFENCE_TIMEOUT_EN.
module sfence_vma_seq
  import sfence_vma_seq_pkg::*;
#(
  parameter int NUM_TLB     = 2,
  parameter int VA_W        = 32,
  parameter int ASID_W      = 9,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  opcode_e            opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [VA_W-1:0]    rs1_val,
  input  logic [31:0]        rs2_val,
  input  priv_e              cur_priv,
  input  logic               tvm,
  output logic [NUM_TLB-1:0] inv_req,
  input  logic [NUM_TLB-1:0] inv_ack,
  output sfence_kind_e       inv_kind,
  output logic [VA_W-1:0]    inv_vaddr,
  output logic [ASID_W-1:0]  inv_asid,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic               timeout
);

  sfence_state_e     state_d, state_q;
  sfence_kind_e      kind_d, kind_q;
  logic [VA_W-1:0]   vaddr_d, vaddr_q;
  logic [ASID_W-1:0] asid_d, asid_q;
  logic ready_d, ready_q, busy_d, busy_q, done_d, done_q;
  logic illegal_d, illegal_q, timeout_d, timeout_q;
  logic load, flush, all_clear, is_sfence, priv_bad;
  logic [NUM_TLB-1:0] pending;
  logic unused_rs2_hi;

`ifdef SFENCE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_d, cnt_q;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  assign unused_rs2_hi = ^rs2_val[31:ASID_W];
  assign is_sfence = (opcode == OPC_SYSTEM) && (funct3 == FUNCT3_PRIV) &&
                     (funct7 == FUNCT7_SFENCE_VMA);
  assign priv_bad  = (cur_priv == PRIV_U) || ((cur_priv == PRIV_S) && tvm);

  sfence_ack_tracker #(.NUM_CH(NUM_TLB)) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .flush     (flush),
    .ack       (inv_ack),
    .pending   (pending),
    .all_clear (all_clear)
  );

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    vaddr_d   = vaddr_q;
    asid_d    = asid_q;
    ready_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    timeout_d = 1'b0;
    load      = 1'b0;
    flush     = 1'b0;
`ifdef SFENCE_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (instr_valid && is_sfence) begin
          if (priv_bad) begin
            illegal_d = 1'b1;
          end else begin
            load    = 1'b1;
            kind_d  = sfence_kind(rs1 != 5'd0, rs2 != 5'd0);
            vaddr_d = rs1_val;
            asid_d  = rs2_val[ASID_W-1:0];
            state_d = ST_REQ;
            ready_d = 1'b0;
            busy_d  = 1'b1;
`ifdef SFENCE_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      ST_REQ: begin
        busy_d  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        busy_d = 1'b1;
        if (all_clear) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
`ifdef SFENCE_TIMEOUT_EN
        // An ack landing in the expiry cycle still wins over the watchdog.
        else if ((cnt_q == CNT_W'(TIMEOUT_CYC - 1)) && (|(pending & ~inv_ack))) begin
          flush     = 1'b1;
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          ready_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      kind_q    <= SFENCE_ALL;
      vaddr_q   <= '0;
      asid_q    <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      vaddr_q   <= vaddr_d;
      asid_q    <= asid_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef SFENCE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign instr_ready = ready_q;
  assign inv_req     = pending;
  assign inv_kind    = kind_q;
  assign inv_vaddr   = vaddr_q;
  assign inv_asid    = asid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_sfence_vma_seq.sv
// tb/tb_sfence_vma_seq.sv - directed and random checks of sfence_vma_seq against a behavioural model
module tb_sfence_vma_seq;
  import sfence_vma_seq_pkg::*;

  localparam int NT = 2;
  localparam int VW = 32;
  localparam int AW = 9;
  localparam int TO = 8;

  logic clk, rst_n, instr_valid, instr_ready, tvm, busy, done, illegal, timeout;
  opcode_e opcode;
  priv_e cur_priv;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2;
  logic [VW-1:0] rs1_val, inv_vaddr;
  logic [31:0] rs2_val;
  logic [NT-1:0] inv_req, inv_ack;
  sfence_kind_e inv_kind;
  logic [AW-1:0] inv_asid;

  sfence_vma_seq #(.NUM_TLB(NT), .VA_W(VW), .ASID_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .cur_priv(cur_priv), .tvm(tvm),
    .inv_req(inv_req), .inv_ack(inv_ack), .inv_kind(inv_kind), .inv_vaddr(inv_vaddr),
    .inv_asid(inv_asid), .busy(busy), .done(done), .illegal(illegal), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: m_age counts cycles since the fence was taken (1 = first request cycle).
  bit m_busy, m_fin, m_done, m_ill, m_to;
  int m_age;
  logic [NT-1:0] m_pend;
  sfence_kind_e m_kind;
  logic [VW-1:0] m_vaddr;
  logic [AW-1:0] m_asid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_fin = 0; m_done = 0; m_ill = 0; m_to = 0; m_age = 0;
      m_pend = '0; m_kind = SFENCE_ALL; m_vaddr = '0; m_asid = '0;
    end else begin
      m_done = 0; m_ill = 0; m_to = 0;
      if (m_fin) begin
        m_fin = 0;
      end else if (m_busy) begin
        if (m_age >= 2 && m_pend == '0) begin
          m_busy = 0; m_fin = 1; m_done = 1;
        end else begin
          m_pend = m_pend & ~inv_ack;
`ifdef SFENCE_TIMEOUT_EN
          if (m_age - 1 == TO && m_pend != '0) begin
            m_busy = 0; m_pend = '0; m_done = 1; m_to = 1;
          end
`endif
          m_age++;
        end
      end else if (instr_valid && opcode == OPC_SYSTEM && funct3 == 3'd0 && funct7 == 7'h09) begin
        if (cur_priv == PRIV_U || (cur_priv == PRIV_S && tvm)) m_ill = 1;
        else begin
          m_busy = 1; m_age = 1; m_pend = '1;
          if (rs1 != 0) m_kind = (rs2 != 0) ? SFENCE_ADDR_ASID : SFENCE_ADDR;
          else          m_kind = (rs2 != 0) ? SFENCE_ASID : SFENCE_ALL;
          m_vaddr = rs1_val;
          m_asid  = rs2_val[AW-1:0];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("ctrl{ready,busy,done,illegal,timeout}", {instr_ready, busy, done, illegal, timeout},
          {!(m_busy || m_fin), m_busy, m_done, m_ill, m_to});
      chk("inv_req", inv_req, m_busy ? m_pend : '0);
      chk("fields{kind,vaddr,asid}", {inv_kind, inv_vaddr, inv_asid}, {m_kind, m_vaddr, m_asid});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input priv_e p, input logic t, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] v1, input logic [31:0] v2, input logic [6:0] f7);
    instr_valid = 1; opcode = OPC_SYSTEM; funct3 = 3'd0; funct7 = f7;
    cur_priv = p; tvm = t; rs1 = r1; rs2 = r2; rs1_val = v1; rs2_val = v2;
    tick;
    instr_valid = 0;
  endtask

  logic [4:0] k_rs1 [4] = '{5'd5, 5'd0, 5'd0, 5'd5};
  logic [4:0] k_rs2 [4] = '{5'd0, 5'd0, 5'd7, 5'd7};
  sfence_kind_e k_exp [4] = '{SFENCE_ADDR, SFENCE_ALL, SFENCE_ASID, SFENCE_ADDR_ASID};

  initial begin
    rst_n = 0; instr_valid = 0; opcode = OPC_OP; funct3 = 0; funct7 = 0; rs1 = 0; rs2 = 0;
    rs1_val = 0; rs2_val = 0; cur_priv = PRIV_M; tvm = 0; inv_ack = '0;
    #12;
    chk("reset ctrl", {instr_ready, busy, done, illegal, timeout}, 5'b10000);
    chk("reset inv_req", inv_req, 2'b00);
    chk("reset fields", {inv_kind, inv_vaddr, inv_asid}, 43'd0);
    @(posedge clk); #2 rst_n = 1;
    cmp_en = 1;
    tick;

    // One legal fence per kind, both acks in cycle 1.
    for (int k = 0; k < 4; k++) begin
      issue(PRIV_S, 0, k_rs1[k], k_rs2[k], 32'h8000_1000, 32'h0000_01FF, 7'h09);
      inv_ack = 2'b11;
      @(negedge clk); chk("c1 inv_req", inv_req, 2'b11);
      tick; inv_ack = 2'b00;
      tick;
      @(negedge clk);
      chk("c3 done", done, 1'b1);
      chk("kind", inv_kind, k_exp[k]);
      chk("vaddr", inv_vaddr, 32'h8000_1000);
      chk("asid", inv_asid, 9'h1FF);
      tick;
      @(negedge clk); chk("c4 ready", instr_ready, 1'b1);
      tick;
    end

    // Staggered acks, with a second fence offered while busy.
    issue(PRIV_S, 0, 5'd5, 5'd0, 32'h1234_5000, 32'd0, 7'h09);
    for (int c = 1; c <= 8; c++) begin
      inv_ack = (c == 2) ? 2'b01 : (c == 6) ? 2'b10 : 2'b00;
      instr_valid = (c == 4);
      @(negedge clk);
      chk("stagger busy", busy, (c <= 7) ? 1'b1 : 1'b0);
      chk("stagger done", done, (c == 8) ? 1'b1 : 1'b0);
      if (c == 3) chk("stagger c3 inv_req", inv_req, 2'b10);
      if (c == 7) chk("stagger c7 inv_req", inv_req, 2'b00);
      if (c == 4) chk("stagger c4 ready", instr_ready, 1'b0);
      tick;
    end
    instr_valid = 0; inv_ack = 0;
    tick;

    // Privilege: U and S+TVM are illegal, M+TVM is legal.
    issue(PRIV_U, 0, 5'd5, 5'd0, 32'h1000, 32'd0, 7'h09);
    @(negedge clk); chk("U illegal", {illegal, inv_req}, 3'b100);
    tick;
    issue(PRIV_S, 1, 5'd5, 5'd0, 32'h1000, 32'd0, 7'h09);
    @(negedge clk); chk("S+tvm illegal", {illegal, inv_req}, 3'b100);
    tick;
    issue(PRIV_M, 1, 5'd0, 5'd0, 32'h1000, 32'd0, 7'h09);
    inv_ack = 2'b11;
    @(negedge clk); chk("M+tvm legal", {illegal, inv_req}, 3'b011);
    tick; inv_ack = 0; tick; tick; tick;

    // Spurious acks in IDLE and a non-matching funct7.
    inv_ack = 2'b11; tick; tick;
    @(negedge clk); chk("spurious ack", {inv_req, busy}, 3'b000);
    inv_ack = 0;
    issue(PRIV_M, 0, 5'd5, 5'd0, 32'h1000, 32'd0, 7'h08);
    @(negedge clk); chk("funct7 08 no req", {inv_req, busy, illegal}, 4'b0000);
    tick;
    @(negedge clk); chk("funct7 08 no done", done, 1'b0);
    tick;

    // Reset while waiting on ack[1].
    issue(PRIV_S, 0, 5'd5, 5'd7, 32'hCAFE_0000, 32'h55, 7'h09);
    inv_ack = 2'b01; tick; inv_ack = 0; tick;
    #1 rst_n = 0;
    #1 chk("async reset", {inv_req, busy, done, instr_ready, inv_kind, inv_vaddr, inv_asid},
           {2'b00, 1'b0, 1'b0, 1'b1, 43'd0});
    @(posedge clk); #2 rst_n = 1;
    @(negedge clk); chk("ready after reset", instr_ready, 1'b1);
    tick;

`ifdef SFENCE_TIMEOUT_EN
    issue(PRIV_S, 0, 5'd5, 5'd0, 32'h2000, 32'd0, 7'h09);
    for (int c = 1; c <= 10; c++) begin
      inv_ack = (c == 1) ? 2'b01 : 2'b00;
      @(negedge clk);
      chk("wd timeout", timeout, (c == 10) ? 1'b1 : 1'b0);
      if (c == 9)  chk("wd c9 inv_req", inv_req, 2'b10);
      if (c == 10) chk("wd c10 done/inv_req", {done, inv_req}, 3'b100);
      tick;
    end
    inv_ack = 0;
    issue(PRIV_S, 0, 5'd5, 5'd0, 32'h3000, 32'd0, 7'h09);
    inv_ack = 2'b11; tick; inv_ack = 0; tick;
    @(negedge clk); chk("after wd done", {done, timeout}, 2'b10);
    tick;
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      instr_valid = ($urandom_range(0, 2) == 0);
      opcode  = ($urandom_range(0, 5) == 0) ? OPC_OP : OPC_SYSTEM;
      funct3  = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd0;
      funct7  = ($urandom_range(0, 5) == 0) ? 7'h08 : 7'h09;
      case ($urandom_range(0, 2))
        0:       cur_priv = PRIV_U;
        1:       cur_priv = PRIV_S;
        default: cur_priv = PRIV_M;
      endcase
      tvm     = $urandom_range(0, 1) == 1;
      rs1     = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rs2     = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rs1_val = $urandom;
      rs2_val = $urandom;
      inv_ack = NT'($urandom);
      tick;
    end
    instr_valid = 0; inv_ack = 0;
    tick;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/sfence_vma_seq.md
Name: sfence_vma_seq

Overview:
Parametrised SFENCE.VMA sequencer for the execute stage. It decodes SFENCE.VMA, checks privilege, and latches the VA and ASID operands. It then broadcasts the invalidate request to NUM_TLB TLB/MMU channels, using a per-channel req/ack handshake. When every channel has acknowledged, it returns a completion pulse. The pipeline stalls on `busy` until that pulse arrives.

Parameters:
NUM_TLB, 2, number of TLB channels (I-TLB, D-TLB, …), at least 1
VA_W, 32, virtual address width
ASID_W, 9, ASID width; taken from rs2_val[ASID_W-1:0]
TIMEOUT_CYC, 1024, ack watchdog limit in cycles; used only with SFENCE_TIMEOUT_EN

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
instr_valid  in  1  decoded instruction offered
instr_ready  out  1  instruction accepted when high with instr_valid
opcode  in  opcode_e  decoded opcode
funct3  in  3  decoded funct3
funct7  in  7  decoded funct7
rs1  in  5  rs1 index
rs2  in  5  rs2 index
rs1_val  in  VA_W  virtual address operand
rs2_val  in  32  ASID operand
cur_priv  in  priv_e  current privilege
tvm  in  1  mstatus.TVM
inv_req  out  NUM_TLB  per-channel invalidate request
inv_ack  in  NUM_TLB  per-channel acknowledge
inv_kind  out  sfence_kind_e  ALL / ADDR / ASID / ADDR_ASID
inv_vaddr  out  VA_W  latched VA
inv_asid  out  ASID_W  latched ASID
busy  out  1  sequence in progress (pipeline stall)
done  out  1  one-cycle completion pulse
illegal  out  1  one-cycle illegal-instruction pulse
timeout  out  1  one-cycle watchdog pulse (0 without macro)

Behaviour:
- Reset: state IDLE; instr_ready=1; inv_req=0, inv_kind=ALL, inv_vaddr=0, inv_asid=0, busy=0, done=0, illegal=0, timeout=0.
- Reset asserted mid-sequence: all outputs return to reset values immediately. TLBs must tolerate inv_req dropping without an ack.
- SFENCE.VMA match: opcode==OPC_SYSTEM, funct3==000, funct7==7'h09.
- instr_ready=1 only in IDLE.
- A non-matching instruction is consumed with no action.
- Accept in IDLE, privilege check:
  - Illegal if cur_priv==PRIV_U, or if cur_priv==PRIV_S and tvm==1.
  - Illegal result: illegal pulses the next cycle; no inv_req; stay in IDLE.
- Accept in IDLE, legal:
  - Latch inv_vaddr=rs1_val and inv_asid=rs2_val[ASID_W-1:0].
  - Latch inv_kind: rs1==0 & rs2==0 → ALL; rs1!=0 & rs2==0 → ADDR; rs1==0 & rs2!=0 → ASID; else ADDR_ASID.
  - Go to REQ.
- Latched fields stay stable while busy.
- States:
  - IDLE → REQ on legal accept.
  - REQ: inv_req=all-ones, pending mask = all-ones, busy=1. Go to WAIT next cycle.
  - WAIT: inv_req = pending mask.
    - A channel bit clears in the cycle after inv_ack[i] is sampled high while inv_req[i] is high.
    - inv_ack[i] while inv_req[i] is low is ignored.
    - Simultaneous acks on several channels all clear in the same cycle.
    - When the mask becomes zero, go to DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Latency: accept in cycle 0; inv_req high in cycle 1. With all acks sampled in cycle 1, done pulses in cycle 3; instr_ready returns high in cycle 4.
- An ack already high in the first REQ cycle counts; the bit then clears at the REQ→WAIT edge.
- busy=1 in REQ and WAIT.

Optional Feature:
Macro: SFENCE_TIMEOUT_EN.
- With the macro:
  - A counter of $clog2(TIMEOUT_CYC+1) bits clears on entry to REQ and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC with the mask non-zero: inv_req drops to 0 and timeout pulses for one cycle together with done; go to IDLE.
  - An ack arriving in the same cycle as expiry still counts; if the mask empties in that cycle, there is no timeout.
- Without the macro: WAIT has no limit; timeout is tied to 0; no counter logic is present.

Decomposition:
- Shared package (harvos_pkg_flat.svh):
  - Existing opcode_e (OPC_SYSTEM) and priv_e (PRIV_U=00, PRIV_S=01, PRIV_M=11).
  - New sfence_kind_e, 2 bits: ALL=0, ADDR=1, ASID=2, ADDR_ASID=3.
  - Constants FUNCT7_SFENCE_VMA=7'h09 and FUNCT3_PRIV=3'b000.
- Sub-module sfence_ack_tracker: generic NUM_TLB-wide pending mask with load, ack-clear, and all-clear flag. Reusable for future HFENCE/FENCE.I broadcasts.

Test Plan:
- Legal fence, with each kind checked separately:
  - Common stimulus: PRIV_S, tvm=0, rs1=5, rs1_val=0x8000_1000, rs2=0, NUM_TLB=2, both acks in the same cycle (cycle 1).
  - ADDR (as above): inv_req=2'b11 in cycle 1; inv_kind=ADDR; inv_vaddr=0x8000_1000; done in cycle 3.
  - ALL (rs1=rs2=0): inv_kind=ALL.
  - ASID (rs1=0, rs2=7, rs2_val=0x1FF): inv_kind=ASID, inv_asid=0x1FF.
  - ADDR_ASID (rs1=5, rs2=7): inv_kind=ADDR_ASID, inv_vaddr=0x8000_1000, inv_asid=0x1FF.
- Staggered acks: ack[0] in cycle 2, ack[1] in cycle 6 → inv_req=01 low then 00; done in cycle 8; busy high in cycles 1–7; instr_valid in cycle 4 is not accepted.
- Privilege: PRIV_U, and PRIV_S with tvm=1 → illegal pulse in cycle 1; inv_req stays 0; PRIV_M with tvm=1 → legal sequence.
- Spurious and non-matching input: inv_ack=11 while IDLE → no effect; funct7=0x08 → consumed, no req, no done.
- Reset mid-WAIT (ack[1] outstanding), rst_n low for 1 cycle → all outputs 0 asynchronously, instr_ready=1 after release.
- With SFENCE_TIMEOUT_EN and TIMEOUT_CYC=8, ack[1] never arrives → timeout and done pulse together at WAIT cycle 8; inv_req=0; the next fence proceeds normally.
